prg_uploader: RTL and testbench
===============================

Name: prg_uploader

Overview:
- Saves the BASIC program held in on-chip RAM back to the HPS as a PRG file. It is the read-side counterpart of the downloader's PRG path.
- On a save trigger it performs these steps in order:
  - holds the CPU;
  - reads the program-end pointer from RAM;
  - computes the program length;
  - requests an upload from hps_io;
  - serves ioctl_rd requests with RAM bytes starting at the program start address.
- It sits between hps_io's upload interface and the read port of the 64 KB RAM DPRAM. The top-level muxes the DPRAM read address to this block while `busy`=1.

Parameters:
- PRG_INDEX, 8'd2, ioctl index used for the upload and matched on ioctl_index.
- PRG_START_ADDR, 16'h5608, RAM address of the first program byte (file offset 0).
- PTR_PROGND, 16'h55E4, RAM address of the 16-bit little-endian program-end pointer.
- TIMEOUT_W, 24, width of the handshake timeout counter.

Ports:
- clk  in  1  system clock (clk_sys).
- reset_n  in  1  asynchronous active-low reset.
- save_trig  in  1  level from the OSD; a rising edge starts a save.
- ioctl_upload  in  1  hps_io upload-active flag.
- ioctl_index  in  8  hps_io file index.
- ioctl_rd  in  1  hps_io one-cycle byte-read strobe.
- ioctl_addr  in  25  hps_io byte offset into the file.
- ioctl_din  out  8  byte returned to hps_io.
- ioctl_upload_req  out  1  one-cycle upload request pulse to hps_io.
- mem_addr  out  16  RAM read address.
- mem_rd  out  1  RAM read qualifier.
- mem_dout  in  8  RAM read data, registered, valid 1 clk after mem_addr.
- busy  out  1  save in progress; the top uses it to hold the CPU (WAIT) and steal the RAM read port.
- upload_size  out  16  computed program length in bytes.
- error  out  1  sticky; set on a bad pointer or a timeout, cleared on the next save_trig edge.

Behaviour:
- Reset values: ioctl_din=0, ioctl_upload_req=0, mem_addr=0, mem_rd=0, busy=0, upload_size=0, error=0, state=IDLE, timeout counter=0.
- Edge detection: save_trig is edge-detected with a registered copy. A new edge while busy is ignored.
- FSM states:
  - IDLE: on a save_trig rising edge, clear error, set busy, and go to RD_LO.
  - RD_LO: mem_addr=PTR_PROGND, mem_rd=1. Next: WT_LO.
  - WT_LO: latch mem_dout into ptr[7:0]. Next: RD_HI.
  - RD_HI: mem_addr=PTR_PROGND+1 (16-bit wrap), mem_rd=1. Next: WT_HI.
  - WT_HI: latch mem_dout into ptr[15:8]. Next: CALC.
  - CALC: if ptr <= PRG_START_ADDR, set error, clear busy, go to IDLE, and issue no request. Otherwise upload_size = ptr - PRG_START_ADDR (16-bit unsigned). Next: REQ.
  - REQ: drive ioctl_upload_req=1 for exactly one cycle, clear the timeout counter. Next: WAIT_UP.
  - WAIT_UP: wait for ioctl_upload=1 with ioctl_index==PRG_INDEX, then go to STREAM. The timeout counter increments each cycle; if it reaches all-ones, set error, clear busy, go to IDLE.
  - STREAM: on ioctl_rd=1, go to FETCH.
    - If ioctl_addr < upload_size: mem_addr = PRG_START_ADDR + ioctl_addr[15:0] (16-bit wrap) and mem_rd=1.
    - Otherwise: no memory access, and the byte is forced to 8'h00.
    - An ioctl_upload falling edge goes to IDLE and clears busy.
  - FETCH: latch mem_dout (or 8'h00) into ioctl_din. Next: STREAM.
- Read latency: ioctl_din is updated 2 clk after ioctl_rd is sampled, and holds until the next update.
- ioctl_rd while in FETCH (back-to-back strobes): queue exactly one pending read and serve it immediately after FETCH. Further strobes are dropped; hps_io spaces strobes by at least 4 clk.
- Upload ending while FETCH is pending: the FETCH completes, then the block goes to IDLE.
- ioctl_upload with a foreign index: ignored in every state. ioctl_din and mem_rd are unaffected.
- Reset mid-operation: asynchronous return to all reset values. No ioctl_upload_req is emitted after reset deassertion until a new save_trig edge.
- mem_rd: asserted only in RD_LO, RD_HI and in-range STREAM reads. mem_addr holds its last value otherwise.

Test Plan:
- Normal save:
  - Stimulus: RAM[55E4]=34, RAM[55E5]=56, RAM[5608..]=AA,BB,CC; pulse save_trig; model hps_io asserting ioctl_upload index 2 and ioctl_rd at addr 0,1,2.
  - Required: upload_size=16'h002C; one-cycle ioctl_upload_req; ioctl_din=AA,BB,CC, each valid 2 clk after its strobe; busy falls after ioctl_upload deasserts.
- Bad pointer:
  - Stimulus: pointer = 5608.
  - Required: error=1; no ioctl_upload_req; busy high for exactly 6 clk (IDLE edge through CALC).
- Out-of-range read:
  - Stimulus: upload_size=3; ioctl_rd at ioctl_addr=3 and ioctl_addr=1000.
  - Required: ioctl_din=00 for both; mem_rd never asserted.
- Timeout:
  - Stimulus: TIMEOUT_W=4; never assert ioctl_upload.
  - Required: error=1 and busy=0 within 18 clk of REQ.
- Foreign index / retrigger:
  - Stimulus: ioctl_upload with index 3 during WAIT_UP; also a save_trig edge while busy.
  - Required: block stays in WAIT_UP; no second request.
- Async reset:
  - Stimulus: assert reset_n=0 during STREAM.
  - Required: all outputs 0 in the same cycle; no request after release.

Source files
------------

// File: rtl/prg_uploader.sv
// prg_uploader: saves the BASIC program from RAM to the HPS as a PRG file.
// Reads the program-end pointer, sizes the upload, then streams RAM bytes on ioctl_rd.
module prg_uploader #(
    parameter logic [7:0]  PRG_INDEX      = 8'd2,
    parameter logic [15:0] PRG_START_ADDR = 16'h5608,
    parameter logic [15:0] PTR_PROGND     = 16'h55E4,
    parameter int          TIMEOUT_W      = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        save_trig,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_upload_req,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_dout,
    output logic        busy,
    output logic [15:0] upload_size,
    output logic        error
);
    typedef enum logic [3:0] {
        IDLE, RD_LO, WT_LO, RD_HI, WT_HI, CALC, REQ, WAIT_UP, STREAM, FETCH
    } state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_ONE = 1;

    state_t                state_q, state_d;
    logic                  trig_q;
    logic [15:0]           ptr_q, ptr_d;
    logic [15:0]           size_q, size_d;
    logic                  err_q, err_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]            din_q, din_d;
    logic                  pend_q, pend_d;
    logic [24:0]           pend_addr_q, pend_addr_d;
    logic                  oor_q, oor_d;
    logic [15:0]           maddr_q;

    logic        start, up_ok, rd_go, in_rng;
    logic [24:0] rd_addr;

    assign start   = (state_q == IDLE) && save_trig && !trig_q;
    assign up_ok   = ioctl_upload && (ioctl_index == PRG_INDEX);
    assign rd_go   = ioctl_rd || pend_q;
    assign rd_addr = pend_q ? pend_addr_q : ioctl_addr;
    assign in_rng  = rd_addr < {9'd0, size_q};

    assign busy        = (state_q != IDLE) || start;
    assign ioctl_din   = din_q;
    assign upload_size = size_q;
    assign error       = err_q;

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        size_d           = size_q;
        err_d            = err_q;
        cnt_d            = cnt_q;
        din_d            = din_q;
        pend_d           = pend_q;
        pend_addr_d      = pend_addr_q;
        oor_d            = oor_q;
        mem_addr         = maddr_q;
        mem_rd           = 1'b0;
        ioctl_upload_req = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                err_d   = 1'b0;
                state_d = RD_LO;
            end
            RD_LO: begin
                mem_addr = PTR_PROGND;
                mem_rd   = 1'b1;
                state_d  = WT_LO;
            end
            WT_LO: begin
                ptr_d[7:0] = mem_dout;
                state_d    = RD_HI;
            end
            RD_HI: begin
                mem_addr = PTR_PROGND + 16'd1;
                mem_rd   = 1'b1;
                state_d  = WT_HI;
            end
            WT_HI: begin
                ptr_d[15:8] = mem_dout;
                state_d     = CALC;
            end
            CALC: if (ptr_q <= PRG_START_ADDR) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                size_d  = ptr_q - PRG_START_ADDR;
                state_d = REQ;
            end
            REQ: begin
                ioctl_upload_req = 1'b1;
                cnt_d            = '0;
                pend_d           = 1'b0;
                state_d          = WAIT_UP;
            end
            WAIT_UP: if (up_ok) state_d = STREAM;
            else if (&cnt_q) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else cnt_d = cnt_q + CNT_ONE;
            // level check suffices: STREAM is only entered with the upload active
            STREAM: if (!up_ok) begin
                pend_d  = 1'b0;
                state_d = IDLE;
            end else if (rd_go) begin
                pend_d  = 1'b0;
                oor_d   = !in_rng;
                state_d = FETCH;
                if (in_rng) begin
                    mem_addr = PRG_START_ADDR + rd_addr[15:0];
                    mem_rd   = 1'b1;
                end
            end
            FETCH: begin
                din_d   = oor_q ? 8'h00 : mem_dout;
                state_d = STREAM;
                if (ioctl_rd && !pend_q) begin
                    pend_d      = 1'b1;
                    pend_addr_d = ioctl_addr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // trig_q resets high so a level already held through reset is not seen as an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            trig_q      <= 1'b1;
            ptr_q       <= '0;
            size_q      <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            din_q       <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            oor_q       <= 1'b0;
            maddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            trig_q      <= save_trig;
            ptr_q       <= ptr_d;
            size_q      <= size_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            din_q       <= din_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            oor_q       <= oor_d;
            maddr_q     <= mem_addr;
        end
    end
endmodule

// File: tb/tb_prg_uploader.sv
// tb_prg_uploader: scenario tasks driving a RAM and hps_io model around prg_uploader.
// Expected bytes come from the file rules: offset a < size gives RAM[start+a], else 00.
module tb_prg_uploader;
    localparam logic [15:0] START = 16'h5608;
    localparam logic [15:0] PTR   = 16'h55E4;

    logic        clk = 0, reset_n = 0, save_trig = 0, ioctl_upload = 0, ioctl_rd = 0;
    logic [7:0]  ioctl_index = 0;
    logic [24:0] ioctl_addr = 0;
    logic [7:0]  ioctl_din, mem_dout;
    logic        ioctl_upload_req, mem_rd, busy, error;
    logic [15:0] mem_addr, upload_size;
    logic [7:0]  ram [0:65535];
    int checks = 0, errs = 0, req_cnt = 0, rd_cnt = 0, busy_cnt = 0;

    prg_uploader #(.TIMEOUT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .save_trig(save_trig), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_upload_req(ioctl_upload_req), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_dout(mem_dout), .busy(busy), .upload_size(upload_size),
        .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_dout <= ram[mem_addr];
    always @(posedge clk) begin
        if (ioctl_upload_req) req_cnt++;
        if (mem_rd) rd_cnt++;
        if (busy) busy_cnt++;
    end

    function automatic logic [7:0] model_byte(input logic [24:0] a, input logic [15:0] size);
        logic [15:0] o;
        o = a[15:0];
        return (a < {9'd0, size}) ? ram[START + o] : 8'h00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ptr(input logic [15:0] p);
        ram[PTR]         = p[7:0];
        ram[PTR + 16'd1] = p[15:8];
    endtask

    task automatic start_save();
        save_trig = 1;
        step();
        save_trig = 0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (ioctl_upload_req) ok = 1;
            else step();
        end
    endtask

    task automatic open_upload();
        ioctl_index  = 8'd2;
        ioctl_upload = 1;
        step();
        step();
    endtask

    task automatic end_upload(output bit idle);
        ioctl_upload = 0;
        idle = 0;
        for (int i = 0; i < 6 && !idle; i++) begin
            step();
            if (!busy) idle = 1;
        end
    endtask

    task automatic do_read(input logic [24:0] a, output logic [7:0] mid, output logic [7:0] got);
        ioctl_rd   = 1;
        ioctl_addr = a;
        step();
        ioctl_rd = 0;
        mid = ioctl_din;
        step();
        got = ioctl_din;
        step();
        step();
    endtask

    task automatic test_reset();
        reset_n = 0;
        step();
        checks++; if (ioctl_din !== 8'h00) begin errs++; $display("FAIL reset_din got %h exp 00", ioctl_din); end
        checks++; if ({ioctl_upload_req, mem_rd, busy, error} !== 4'b0) begin errs++; $display("FAIL reset_flags got %b exp 0000", {ioctl_upload_req, mem_rd, busy, error}); end
        checks++; if ({mem_addr, upload_size} !== 32'h0) begin errs++; $display("FAIL reset_addr_size got %h exp 0", {mem_addr, upload_size}); end
        reset_n = 1;
        step();
    endtask

    task automatic test_normal();
        bit ok;
        int r0;
        logic [7:0] mid, got, prev;
        logic [7:0] exp_b [3] = '{8'hAA, 8'hBB, 8'hCC};
        set_ptr(16'h5634);
        for (int i = 0; i < 3; i++) ram[START + 16'(i)] = exp_b[i];
        r0 = req_cnt;
        start_save();
        wait_req(ok);
        checks++; if (!ok) begin errs++; $display("FAIL normal_req got none exp pulse"); end
        step();
        checks++; if (ioctl_upload_req !== 1'b0) begin errs++; $display("FAIL normal_req_width got %b exp 0", ioctl_upload_req); end
        checks++; if (upload_size !== 16'h002C) begin errs++; $display("FAIL normal_size got %h exp 002c", upload_size); end
        open_upload();
        for (int i = 0; i < 3; i++) begin
            prev = ioctl_din;
            do_read(25'(i), mid, got);
            checks++; if (mid !== prev) begin errs++; $display("FAIL normal_early[%0d] got %h exp %h", i, mid, prev); end
            checks++; if (got !== exp_b[i]) begin errs++; $display("FAIL normal_byte[%0d] got %h exp %h", i, got, exp_b[i]); end
        end
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL normal_busy_stream got %b exp 1", busy); end
        end_upload(ok);
        checks++; if (!ok) begin errs++; $display("FAIL normal_busy_end got %b exp 0", busy); end
        checks++; if (req_cnt - r0 != 1) begin errs++; $display("FAIL normal_req_count got %0d exp 1", req_cnt - r0); end
    endtask

    task automatic test_random();
        bit ok;
        logic [15:0] size, p;
        logic [24:0] a;
        logic [7:0] mid, got;
        for (int it = 0; it < 4; it++) begin
            size = 16'($urandom_range(1, 60));
            p = START + size;
            set_ptr(p);
            for (int i = 0; i < 70; i++) ram[START + 16'(i)] = 8'($urandom);
            start_save();
            wait_req(ok);
            checks++; if (!ok) begin errs++; $display("FAIL rand_req[%0d] got none exp pulse", it); end
            checks++; if (upload_size !== p - START) begin errs++; $display("FAIL rand_size[%0d] got %h exp %h", it, upload_size, p - START); end
            open_upload();
            for (int k = 0; k < 4; k++) begin
                a = (k == 3) ? 25'($urandom_range(61, 30000)) : 25'($urandom_range(0, int'(size) + 4));
                do_read(a, mid, got);
                checks++; if (got !== model_byte(a, size)) begin errs++; $display("FAIL rand_byte[%0d] addr %0d got %h exp %h", it, a, got, model_byte(a, size)); end
            end
            end_upload(ok);
        end
    endtask

    task automatic test_bad_ptr();
        logic [15:0] bad [2];
        int b0, r0;
        bad[0] = START;
        bad[1] = START - 16'($urandom_range(1, 2000));
        for (int i = 0; i < 2; i++) begin
            set_ptr(bad[i]);
            b0 = busy_cnt;
            r0 = req_cnt;
            start_save();
            for (int k = 0; k < 12; k++) step();
            checks++; if (error !== 1'b1) begin errs++; $display("FAIL bad_error[%0d] got %b exp 1", i, error); end
            checks++; if (busy_cnt - b0 != 6) begin errs++; $display("FAIL bad_busy_len[%0d] got %0d exp 6", i, busy_cnt - b0); end
            checks++; if (req_cnt != r0) begin errs++; $display("FAIL bad_req[%0d] got %0d exp 0", i, req_cnt - r0); end
        end
    endtask

    task automatic test_out_of_range();
        bit ok;
        int r0;
        logic [7:0] mid, got;
        set_ptr(START + 16'd3);
        ram[START] = 8'h5A;
        start_save();
        wait_req(ok);
        checks++; if (error !== 1'b0) begin errs++; $display("FAIL oor_error_clear got %b exp 0", error); end
        checks++; if (upload_size !== 16'd3) begin errs++; $display("FAIL oor_size got %h exp 0003", upload_size); end
        open_upload();
        do_read(25'd0, mid, got);
        checks++; if (got !== 8'h5A) begin errs++; $display("FAIL oor_inrange got %h exp 5a", got); end
        r0 = rd_cnt;
        do_read(25'd3, mid, got);
        checks++; if (got !== 8'h00) begin errs++; $display("FAIL oor_addr3 got %h exp 00", got); end
        do_read(25'd1000, mid, got);
        checks++; if (got !== 8'h00) begin errs++; $display("FAIL oor_addr1000 got %h exp 00", got); end
        checks++; if (rd_cnt != r0) begin errs++; $display("FAIL oor_mem_rd got %0d exp 0", rd_cnt - r0); end
        end_upload(ok);
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] got;
        set_ptr(START + 16'd20);
        ram[START + 16'd2] = 8'h11;
        ram[START + 16'd7] = 8'h22;
        start_save();
        wait_req(ok);
        open_upload();
        ioctl_rd = 1;
        ioctl_addr = 25'd2;
        step();
        ioctl_addr = 25'd7;
        step();
        ioctl_rd = 0;
        got = ioctl_din;
        checks++; if (got !== 8'h11) begin errs++; $display("FAIL b2b_first got %h exp 11", got); end
        step();
        step();
        checks++; if (ioctl_din !== 8'h22) begin errs++; $display("FAIL b2b_second got %h exp 22", ioctl_din); end
        step();
        step();
        end_upload(ok);
    endtask

    task automatic test_timeout();
        bit ok, idle;
        int n;
        set_ptr(START + 16'd5);
        start_save();
        wait_req(ok);
        checks++; if (!ok) begin errs++; $display("FAIL timeout_req got none exp pulse"); end
        idle = 0;
        n = 0;
        while (!idle && n < 25) begin
            step();
            n++;
            if (!busy) idle = 1;
        end
        checks++; if (!idle || n > 18) begin errs++; $display("FAIL timeout_len got %0d clk exp <=18", n); end
        checks++; if (error !== 1'b1) begin errs++; $display("FAIL timeout_error got %b exp 1", error); end
    endtask

    task automatic test_foreign();
        bit ok;
        int r0, m0;
        logic [7:0] mid, got, d0;
        set_ptr(START + 16'd4);
        ram[START + 16'd1] = 8'h77;
        start_save();
        wait_req(ok);
        step();
        r0 = req_cnt;
        m0 = rd_cnt;
        d0 = ioctl_din;
        ioctl_index = 8'd3;
        ioctl_upload = 1;
        for (int i = 0; i < 4; i++) step();
        save_trig = 1;
        step();
        save_trig = 0;
        for (int i = 0; i < 4; i++) step();
        checks++; if (busy !== 1'b1 || error !== 1'b0) begin errs++; $display("FAIL foreign_wait got busy %b err %b exp 1 0", busy, error); end
        checks++; if (rd_cnt != m0 || ioctl_din !== d0) begin errs++; $display("FAIL foreign_side got rd %0d din %h exp 0 %h", rd_cnt - m0, ioctl_din, d0); end
        open_upload();
        do_read(25'd1, mid, got);
        checks++; if (got !== 8'h77) begin errs++; $display("FAIL foreign_resume got %h exp 77", got); end
        end_upload(ok);
        checks++; if (req_cnt != r0) begin errs++; $display("FAIL retrigger_req got %0d exp 0", req_cnt - r0); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int r0;
        logic [7:0] mid, got;
        set_ptr(START + 16'd6);
        ram[START] = 8'h9C;
        start_save();
        wait_req(ok);
        open_upload();
        do_read(25'd0, mid, got);
        ioctl_rd = 1;
        ioctl_addr = 25'd1;
        #2;
        reset_n = 0;
        save_trig = 1;
        #1;
        checks++; if ({ioctl_upload_req, mem_rd, busy, error} !== 4'b0 || ioctl_din !== 8'h00) begin errs++; $display("FAIL areset_flags got %b din %h exp 0000 00", {ioctl_upload_req, mem_rd, busy, error}, ioctl_din); end
        checks++; if ({mem_addr, upload_size} !== 32'h0) begin errs++; $display("FAIL areset_addr_size got %h exp 0", {mem_addr, upload_size}); end
        ioctl_rd = 0;
        ioctl_upload = 0;
        step();
        step();
        reset_n = 1;
        r0 = req_cnt;
        for (int i = 0; i < 30; i++) step();
        checks++; if (req_cnt != r0 || busy !== 1'b0) begin errs++; $display("FAIL areset_no_req got %0d busy %b exp 0 0", req_cnt - r0, busy); end
        save_trig = 0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        test_reset();
        test_normal();
        test_random();
        test_bad_ptr();
        test_out_of_range();
        test_back_to_back();
        test_timeout();
        test_foreign();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
